// File: rtl/commit_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_pkg
// Purpose  : Shared types and constants for the commit trace transmitter.
// Revision : 1.0
// ============================================================================
package commit_trace_pkg;

    localparam logic [7:0] c_hdr_magic = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PC    = 3'd2,
        ST_INSTR = 3'd3,
        ST_WDATA = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic [7:0]  seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_rec_t;

    function automatic logic [31:0] make_hdr(input trace_rec_t rec, input logic ovf);
        return {c_hdr_magic, rec.seq, ovf, 9'd0, rec.we, rec.waddr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Purpose  : Synchronous record FIFO exposing the head and the entry behind it.
// Revision : 1.0
// ============================================================================
module trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   push,
    input  trace_rec_t             push_data,
    input  logic                   pop,
    output trace_rec_t             head,
    output trace_rec_t             head_next,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_one = CW'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    trace_rec_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] w_rd_next;

    assign w_rd_next = r_rd_ptr + c_ptr_one;
    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[w_rd_next];

    always_ff @(posedge clk_in) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + c_one;
                2'b01:   count <= count - c_one;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_trace_tx.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_tx
// Purpose  : Buffers retired-instruction records and serializes them as a
//            32-bit word stream. Define COMMIT_TRACE_SEQ_EN to carry a
//            sequence number in each header.
// Revision : 1.0
// ============================================================================
module commit_trace_tx
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   commit_valid,
    input  logic [31:0]            commit_pc,
    input  logic [31:0]            commit_instr,
    input  logic                   commit_we,
    input  logic [4:0]             commit_waddr,
    input  logic [31:0]            commit_wdata,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [31:0]            tx_data,
    output logic                   tx_last,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);
    localparam logic [CW-1:0] c_one  = CW'(1);

    tx_state_t  r_state;
    trace_rec_t w_push_rec;
    trace_rec_t w_head;
    trace_rec_t w_head_next;
    trace_rec_t w_next_rec;
    logic       w_hs;
    logic       w_pop;
    logic       w_full;
    logic       w_push;
    logic       w_drop;
    logic       w_more;
    logic [7:0] w_seq;

`ifdef COMMIT_TRACE_SEQ_EN
    logic [7:0] r_seq;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_seq <= 8'h00;
        end else if (w_push) begin
            r_seq <= r_seq + 8'h01;
        end
    end

    assign w_seq = r_seq;
`else
    assign w_seq = 8'h00;
`endif

    always_comb begin
        w_push_rec       = '0;
        w_push_rec.seq   = w_seq;
        w_push_rec.pc    = commit_pc;
        w_push_rec.instr = commit_instr;
        w_push_rec.we    = commit_we;
        w_push_rec.waddr = commit_waddr;
        w_push_rec.wdata = commit_wdata;
    end

    assign w_hs   = tx_valid & tx_ready;
    assign w_pop  = w_hs & tx_last;
    assign w_full = (fifo_count == c_full);
    assign w_push = commit_valid & (~w_full | w_pop);
    assign w_drop = commit_valid & w_full & ~w_pop;

    // Lookahead for the record that follows the one being popped; when only
    // one entry is buffered the successor can only be the word pushed now.
    assign w_more     = (fifo_count > c_one) | w_push;
    assign w_next_rec = (fifo_count > c_one) ? w_head_next : w_push_rec;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_rec),
        .pop       (w_pop),
        .head      (w_head),
        .head_next (w_head_next),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 32'd0;
            tx_last  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (fifo_count != '0) begin
                        r_state  <= ST_HDR;
                        tx_valid <= 1'b1;
                        tx_data  <= make_hdr(w_head, overflow);
                        tx_last  <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (w_hs) begin
                        r_state <= ST_PC;
                        tx_data <= w_head.pc;
                    end
                end
                ST_PC: begin
                    if (w_hs) begin
                        r_state <= ST_INSTR;
                        tx_data <= w_head.instr;
                        tx_last <= ~w_head.we;
                    end
                end
                ST_INSTR, ST_WDATA: begin
                    if (w_hs) begin
                        if ((r_state == ST_INSTR) && w_head.we) begin
                            r_state <= ST_WDATA;
                            tx_data <= w_head.wdata;
                            tx_last <= 1'b1;
                        end else if (w_more) begin
                            r_state <= ST_HDR;
                            tx_data <= make_hdr(w_next_rec, overflow);
                            tx_last <= 1'b0;
                        end else begin
                            r_state  <= ST_IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 32'd0;
                            tx_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= 32'd0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_tx
// Purpose  : Directed self-checking bench for commit_trace_tx.
// Revision : 1.0
// ============================================================================
module tb_commit_trace_tx;

    localparam int DEPTH = 8;

    logic                   clk_in = 1'b0;
    logic                   reset = 1'b0;
    logic                   commit_valid = 1'b0;
    logic [31:0]            commit_pc = '0;
    logic [31:0]            commit_instr = '0;
    logic                   commit_we = 1'b0;
    logic [4:0]             commit_waddr = '0;
    logic [31:0]            commit_wdata = '0;
    logic                   tx_ready = 1'b0;
    logic                   tx_valid;
    logic [31:0]            tx_data;
    logic                   tx_last;
    logic                   overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [15:0] hdr_lo;
        int          nwords;
    } vec_t;

    commit_trace_tx #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .commit_we    (commit_we),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_seq(input int n);
        logic [7:0] s;
        s = 8'(n);
`ifndef COMMIT_TRACE_SEQ_EN
        s = 8'h00;
`endif
        return s;
    endfunction

    function automatic logic [31:0] hdr_of(input logic we, input logic [4:0] waddr,
                                           input logic [7:0] seq, input logic ovf);
        return {8'hA5, seq, ovf, 9'd0, we, waddr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdata);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = instr;
        commit_we    = we;
        commit_waddr = waddr;
        commit_wdata = wdata;
    endtask

    // Expects the header to be on the bus now and tx_ready=1; leaves the bus after the record.
    task automatic expect_rec(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                              input logic we, input logic [31:0] wdata,
                              input logic [31:0] hdr, input logic [31:0] hmask);
        chk({nm, "/hdr_valid"}, 32'(tx_valid), 32'd1);
        chk({nm, "/hdr"}, tx_data & hmask, hdr & hmask);
        chk({nm, "/hdr_last"}, 32'(tx_last), 32'd0);
        tick();
        chk({nm, "/pc"}, tx_data, pc);
        chk({nm, "/pc_last"}, 32'(tx_last), 32'd0);
        tick();
        chk({nm, "/instr"}, tx_data, instr);
        chk({nm, "/instr_last"}, 32'(tx_last), 32'(!we));
        tick();
        if (we) begin
            chk({nm, "/wdata"}, tx_data, wdata);
            chk({nm, "/wdata_last"}, 32'(tx_last), 32'd1);
            tick();
        end
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] exp_d[9];
        logic        exp_l[9];
        logic [7:0]  s0;

        vecs[0] = '{32'h00400000, 32'h20010005, 1'b1, 5'd1,  32'h00000005, 16'h0021, 4};
        vecs[1] = '{32'h00400004, 32'h08100000, 1'b0, 5'd0,  32'hDEADBEEF, 16'h0000, 3};
        vecs[2] = '{32'h00400008, 32'h00000013, 1'b1, 5'd31, 32'hFFFFFFFF, 16'h003F, 4};
        vecs[3] = '{32'h80000000, 32'h00000000, 1'b0, 5'd5,  32'h12345678, 16'h0005, 3};
        vecs[4] = '{32'hFFFFFFFC, 32'hABCD1234, 1'b1, 5'd10, 32'h00000000, 16'h002A, 4};

        // Reset, with commit_valid asserted to show it is ignored
        drive(32'h11111111, 32'h22222222, 1'b1, 5'd3, 32'h33333333);
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("rst/tx_valid", 32'(tx_valid), 32'd0);
        chk("rst/tx_last", 32'(tx_last), 32'd0);
        chk("rst/tx_data", tx_data, 32'd0);
        chk("rst/overflow", 32'(overflow), 32'd0);
        chk("rst/fifo_count", 32'(fifo_count), 32'd0);
        commit_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst/tx_valid", 32'(tx_valid), 32'd0);

        // Table-driven single records
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].pc, vecs[i].instr, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            tick();
            commit_valid = 1'b0;
            chk($sformatf("vec%0d/count_after_push", i), 32'(fifo_count), 32'd1);
            chk($sformatf("vec%0d/valid_at_push_edge", i), 32'(tx_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d/valid", i), 32'(tx_valid), 32'd1);
            chk($sformatf("vec%0d/hdr", i), tx_data, {8'hA5, exp_seq(n_acc), vecs[i].hdr_lo});
            chk($sformatf("vec%0d/pc", i), 32'(vecs[i].nwords), vecs[i].we ? 32'd4 : 32'd3);
            expect_rec($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].we,
                       vecs[i].wdata, {8'hA5, exp_seq(n_acc), vecs[i].hdr_lo}, 32'hFFFFFFFF);
            chk($sformatf("vec%0d/idle_after", i), 32'(tx_valid), 32'd0);
            chk($sformatf("vec%0d/empty_after", i), 32'(fifo_count), 32'd0);
            n_acc++;
        end

        // Stall for 10 cycles on the PC word
        drive(32'h00001000, 32'h00A00093, 1'b1, 5'd1, 32'h0000000A);
        tick();
        commit_valid = 1'b0;
        tick();
        chk("stall/hdr", tx_data, hdr_of(1'b1, 5'd1, exp_seq(n_acc), 1'b0));
        tick();
        tx_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall/pc_c%0d", c), tx_data, 32'h00001000);
            chk($sformatf("stall/valid_c%0d", c), 32'(tx_valid), 32'd1);
            chk($sformatf("stall/last_c%0d", c), 32'(tx_last), 32'd0);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        chk("stall/instr", tx_data, 32'h00A00093);
        chk("stall/instr_last", 32'(tx_last), 32'd0);
        tick();
        chk("stall/wdata", tx_data, 32'h0000000A);
        chk("stall/wdata_last", 32'(tx_last), 32'd1);
        tick();
        chk("stall/idle", 32'(tx_valid), 32'd0);
        n_acc++;

        // Back-to-back records, including a push on the same edge as a pop of the only entry
        for (int r = 0; r < 3; r++) begin
            exp_d[3*r]     = hdr_of(1'b0, 5'(r + 2), exp_seq(n_acc + r), 1'b0);
            exp_d[3*r + 1] = 32'h00002000 + 32'(r * 4);
            exp_d[3*r + 2] = 32'h00C00000 + 32'(r);
            exp_l[3*r]     = 1'b0;
            exp_l[3*r + 1] = 1'b0;
            exp_l[3*r + 2] = 1'b1;
        end
        for (int c = 0; c < 10; c++) begin
            commit_valid = 1'b0;
            if (c == 0) drive(32'h00002000, 32'h00C00000, 1'b0, 5'd2, 32'h0);
            if (c == 4) drive(32'h00002004, 32'h00C00001, 1'b0, 5'd3, 32'h0);
            if (c == 5) drive(32'h00002008, 32'h00C00002, 1'b0, 5'd4, 32'h0);
            tick();
            commit_valid = 1'b0;
            if (c >= 1) begin
                chk($sformatf("b2b/valid_w%0d", c - 1), 32'(tx_valid), 32'd1);
                chk($sformatf("b2b/data_w%0d", c - 1), tx_data, exp_d[c - 1]);
                chk($sformatf("b2b/last_w%0d", c - 1), 32'(tx_last), 32'(exp_l[c - 1]));
            end
        end
        tick();
        chk("b2b/idle", 32'(tx_valid), 32'd0);
        n_acc += 3;

        // 300 records so the sequence number wraps
        for (int r = 0; r < 300; r++) begin
            drive(32'h00010000 + 32'(r), 32'h00000013, 1'b0, 5'd0, 32'h0);
            tick();
            commit_valid = 1'b0;
            tick();
            chk($sformatf("wrap/seq_r%0d", r), 32'(tx_data[23:16]), 32'(exp_seq(n_acc)));
            repeat (3) tick();
            n_acc++;
        end
        chk("wrap/idle", 32'(tx_valid), 32'd0);

        // Overflow: sink stalled, 10 commits into an 8-deep FIFO
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h00003000 + 32'(i * 4), 32'h00E00000 + 32'(i), 1'b0, 5'(i), 32'h0);
            tick();
        end
        commit_valid = 1'b0;
        chk("ovf/fifo_count", 32'(fifo_count), 32'(DEPTH));
        chk("ovf/overflow", 32'(overflow), 32'd1);
        chk("ovf/held_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_rec($sformatf("ovf/rec%0d", i), 32'h00003000 + 32'(i * 4),
                       32'h00E00000 + 32'(i), 1'b0, 32'h0,
                       hdr_of(1'b0, 5'(i), exp_seq(n_acc + i), 1'b1),
                       (i == 0) ? 32'hFFFF7FFF : 32'hFFFFFFFF);
        end
        n_acc += 8;
        chk("ovf/idle", 32'(tx_valid), 32'd0);
        chk("ovf/empty", 32'(fifo_count), 32'd0);
        chk("ovf/sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a record with another record buffered
        drive(32'h00004000, 32'h00F00000, 1'b1, 5'd7, 32'h77777777);
        tick();
        drive(32'h00004004, 32'h00F00001, 1'b1, 5'd8, 32'h88888888);
        tick();
        commit_valid = 1'b0;
        tick();
        chk("rstmid/on_pc", tx_data, 32'h00004000);
        reset = 1'b0;
        tick();
        chk("rstmid/valid", 32'(tx_valid), 32'd0);
        chk("rstmid/count", 32'(fifo_count), 32'd0);
        chk("rstmid/overflow", 32'(overflow), 32'd0);
        chk("rstmid/data", tx_data, 32'd0);
        reset = 1'b1;
        n_acc = 0;
        tick();
        tick();
        chk("rstmid/no_resume", 32'(tx_valid), 32'd0);
        drive(32'h00005000, 32'h01000000, 1'b0, 5'd9, 32'h0);
        tick();
        commit_valid = 1'b0;
        tick();
        s0 = exp_seq(0);
        chk("rstmid/new_seq", 32'(tx_data[23:16]), 32'(s0));
        expect_rec("rstmid/new", 32'h00005000, 32'h01000000, 1'b0, 32'h0,
                   32'hA5000009, 32'hFFFFFFFF);
        chk("rstmid/final_idle", 32'(tx_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
